// File: rtl/rv_mem_arb.sv
// rv_mem_arb: arbitrates a fetch port and a data port onto one single-port
// memory. Grants are combinational (at most one per cycle); the response is
// returned to the owner of the previous cycle's grant, so full throughput is
// possible with response N overlapping grant N+1.
//
// Optional feature macro: RV_MEM_ARB_FAIRNESS_EN
//   defined   - fetch wins for one cycle after STARVE_MAX consecutive denials
//   undefined - data always wins; fetch may starve
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch read request (byte address)
//   if_gnt/if_rvalid/if_rdata     fetch accept, response valid, read data
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be                data request (read or byte-enabled write)
//   dm_gnt/dm_rvalid/dm_rdata     data accept, response/write-ack, read data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be              memory access strobe and command
//   mem_rdata                     memory read data, one cycle after a read
module rv_mem_arb #(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic [3:0]    dm_be,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [31:0]   dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t owner_r;
    logic   owner_we_r;
    logic   grant_if_s;
    logic   grant_dm_s;
    logic   fetch_priority_s;

`ifdef RV_MEM_ARB_FAIRNESS_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt_r;

    // Fetch takes priority once it has been denied STARVE_MAX cycles in a row.
    always_comb begin
        fetch_priority_s = 1'b0;
        if (if_req && (starve_cnt_r == SW'(STARVE_MAX))) begin
            fetch_priority_s = 1'b1;
        end else begin
            fetch_priority_s = 1'b0;
        end
    end

    // Count consecutive denied fetch cycles, saturating at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (!if_req || grant_if_s) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r != SW'(STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign fetch_priority_s = 1'b0;
`endif

    // Arbitration: fairness override, then data over fetch.
    always_comb begin
        grant_if_s = 1'b0;
        grant_dm_s = 1'b0;
        if (rst) begin
            grant_if_s = 1'b0;
            grant_dm_s = 1'b0;
        end else if (fetch_priority_s) begin
            grant_if_s = 1'b1;
        end else if (dm_req) begin
            grant_dm_s = 1'b1;
        end else if (if_req) begin
            grant_if_s = 1'b1;
        end else begin
            grant_if_s = 1'b0;
            grant_dm_s = 1'b0;
        end
    end

    assign if_gnt = grant_if_s;
    assign dm_gnt = grant_dm_s;

    // Steer the granted requester's command onto the memory port; idle is all-zero.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        mem_be    = 4'h0;
        if (grant_dm_s) begin
            mem_req   = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr[AW+1:2];
            mem_wdata = dm_wdata;
            mem_be    = dm_be;
        end else if (grant_if_s) begin
            mem_req   = 1'b1;
            mem_we    = 1'b0;
            mem_addr  = if_addr[AW+1:2];
            mem_wdata = 32'h0000_0000;
            mem_be    = 4'hF;
        end else begin
            mem_req   = 1'b0;
        end
    end

    // Owner of the access issued this cycle; it receives next cycle's response.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r    <= OWN_NONE;
            owner_we_r <= 1'b0;
        end else if (grant_dm_s) begin
            owner_r    <= OWN_DM;
            owner_we_r <= dm_we;
        end else if (grant_if_s) begin
            owner_r    <= OWN_IF;
            owner_we_r <= 1'b0;
        end else begin
            owner_r    <= OWN_NONE;
            owner_we_r <= 1'b0;
        end
    end

    // Route the response to its owner; rst masks a response still in flight.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = 32'h0000_0000;
        dm_rvalid = 1'b0;
        dm_rdata  = 32'h0000_0000;
        if (rst) begin
            if_rvalid = 1'b0;
            dm_rvalid = 1'b0;
        end else begin
            case (owner_r)
                OWN_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                OWN_DM: begin
                    dm_rvalid = 1'b1;
                    // A write acknowledge carries no data.
                    dm_rdata  = owner_we_r ? 32'h0000_0000 : mem_rdata;
                end
                default: begin
                    if_rvalid = 1'b0;
                    dm_rvalid = 1'b0;
                end
            endcase
        end
    end

    // Byte-offset and out-of-range address bits are intentionally ignored.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{if_addr[31:AW+2], if_addr[1:0],
                                  dm_addr[31:AW+2], dm_addr[1:0]};

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: directed vectors with literal expectations, plus a
// behavioural model (grant rules, previous-cycle owner, starvation count)
// checked against every output on every falling clock edge.
module tb_rv_mem_arb;
    localparam int AW         = 10;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = 32'h0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0]   dm_addr = 32'h0, dm_wdata = 32'h0;
    logic [3:0]    dm_be = 4'h0;
    logic          dm_gnt, dm_rvalid;
    logic [31:0]   dm_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata = 32'h0;

    int n_vec  = 0;
    int n_miss = 0;

    rv_mem_arb #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_prev    = 0;   // 0 none, 1 fetch, 2 data: who was granted last cycle
    int m_prev_we = 0;
    int m_starve  = 0;   // consecutive denied fetch cycles

    function automatic int model_grant();
        if (rst) return 0;
`ifdef RV_MEM_ARB_FAIRNESS_EN
        if (if_req && m_starve == STARVE_MAX) return 1;
`endif
        if (dm_req) return 2;
        if (if_req) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a >> 2) % (32'd1 << AW);
    endfunction

    // Advance the model state at every active edge.
    always @(posedge clk) begin
        int g;
        g = model_grant();
        m_prev    <= g;
        m_prev_we <= (g == 2) ? int'(dm_we) : 0;
        if (rst || !if_req || g == 1) m_starve <= 0;
        else if (m_starve < STARVE_MAX) m_starve <= m_starve + 1;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int g;
        logic ifv, dmv;
        g   = model_grant();
        ifv = !rst && m_prev == 1;
        dmv = !rst && m_prev == 2;
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, g == 1});
        chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, g == 2});
        chk("mem_req", {31'd0, mem_req}, {31'd0, g != 0});
        if (g == 2) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, dm_we});
            chk("mem_addr", {22'd0, mem_addr}, word_of(dm_addr));
            chk("mem_wdata", mem_wdata, dm_wdata);
            chk("mem_be", {28'd0, mem_be}, {28'd0, dm_be});
        end else if (g == 1) begin
            chk("mem_we", {31'd0, mem_we}, 32'd0);
            chk("mem_addr", {22'd0, mem_addr}, word_of(if_addr));
            chk("mem_be", {28'd0, mem_be}, 32'hF);
        end else begin
            chk("mem_we", {31'd0, mem_we}, 32'd0);
        end
        if (rst) begin
            chk("rst_addr", {22'd0, mem_addr}, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
            chk("rst_be", {28'd0, mem_be}, 32'd0);
        end
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, ifv});
        chk("if_rdata", if_rdata, ifv ? mem_rdata : 32'd0);
        chk("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, dmv});
        chk("dm_rdata", dm_rdata, (dmv && m_prev_we == 0) ? mem_rdata : 32'd0);
    end

    // ---------------- stimulus ----------------
    // One cycle of inputs: applied just after an edge, settled 2 time units later.
    task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] mr);
        @(posedge clk);
        #1;
        rst = r; if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = wd; dm_be = be;
        mem_rdata = mr;
        #2;
    endtask

    initial begin
        int first_if, n_if;

        // Reset with both requests high: nothing may be granted.
        step(1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'h20, 32'h1, 4'hF, 32'h55);
        step(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h20, 32'h1, 4'hF, 32'h55);
        chk("rst_gnt", {30'd0, if_gnt, dm_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("post_rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

        // Fetch only.
        step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("fetch_gnt", {31'd0, if_gnt}, 32'd1);
        chk("fetch_addr", {22'd0, mem_addr}, 32'd2);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13);
        chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'h13);

        // Collision: data wins, fetch follows once data drops.
        step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0);
        chk("coll_gnt", {30'd0, if_gnt, dm_gnt}, 32'd1);
        chk("coll_addr", {22'd0, mem_addr}, 32'h40);
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5);
        chk("coll_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("coll_dm_rdata", dm_rdata, 32'hA5A5A5A5);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h77);
        chk("coll_if_rdata", if_rdata, 32'h77);

        // Write with partial byte enables.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'b0011, 32'h0);
        chk("wr_we", {31'd0, mem_we}, 32'd1);
        chk("wr_addr", {22'd0, mem_addr}, 32'd8);
        chk("wr_be", {28'd0, mem_be}, 32'h3);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234);
        chk("wr_ack", {31'd0, dm_rvalid}, 32'd1);
        chk("wr_ack_data", dm_rdata, 32'd0);

        // High and byte-offset address bits are dropped.
        step(1'b0, 1'b1, 32'hFFFFF00B, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("addr_trunc", {22'd0, mem_addr}, 32'd2);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);

        // Both requesters held high for 10 cycles.
        first_if = 0;
        n_if = 0;
        for (int c = 1; c <= 10; c++) begin
            step(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 32'(c));
            if (if_gnt) begin
                n_if = n_if + 1;
                if (first_if == 0) first_if = c;
            end
        end
`ifdef RV_MEM_ARB_FAIRNESS_EN
        chk("fair_first", 32'(first_if), 32'd5);
        chk("fair_count", 32'(n_if), 32'd2);
`else
        chk("starve_count", 32'(n_if), 32'd0);
`endif
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);

        // Reset right after a granted read drops its response.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0);
        chk("rmr_gnt", {31'd0, dm_gnt}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h99);
        chk("rmr_rvalid_rst", {31'd0, dm_rvalid}, 32'd0);
        chk("rmr_rdata_rst", dm_rdata, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h99);
        chk("rmr_rvalid_after", {31'd0, dm_rvalid}, 32'd0);

        // Streaming: alternate fetch and data every cycle.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                step(1'b0, 1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'(100 + i));
            else
                step(1'b0, 1'b0, 32'h0, 1'b1, 1'(i % 4 == 3), 32'(i * 16), 32'(i), 4'hF, 32'(100 + i));
            chk("str_gnt", {30'd0, if_gnt, dm_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i > 0)
                chk("str_rvalid", {30'd0, if_rvalid, dm_rvalid}, (i % 2 == 1) ? 32'd2 : 32'd1);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1);
        chk("str_last_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("str_last_wack", dm_rdata, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
